segment_ex_mem_elastic: RTL and testbench

- Parametrised EX/MEM pipeline boundary register, successor to the fixed 32-bit EX/MEM latch.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from MEM (e.g. multi-cycle memory) stalls EX without losing results.
- Adds a synchronous flush for branch/exception squash, bubble gating of control outputs, and a saturating stall counter for performance monitoring.
- Sits between the EX stage (ALU, store-data mux) and the MEM stage (data memory, writeback path).

---
 rtl/segment_ex_mem_elastic.sv | 118 +++++++++++
 tb/tb_segment_ex_mem_elastic.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/segment_ex_mem_elastic.sv
// EX/MEM pipeline boundary: valid/ready handshake with a 2-entry skid buffer, synchronous flush,
// bubble-gated control outputs and a saturating stall counter. State updates on the falling edge.
module segment_ex_mem_elastic #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mem_to_reg_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  reg_write_in,
  input  logic [DATA_W-1:0]     alu_in,
  input  logic [DATA_W-1:0]     rd3_in,
  input  logic [REG_ADDR_W-1:0] rr3_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  mem_to_reg_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  reg_write_out,
  output logic [DATA_W-1:0]     alu_out,
  output logic [DATA_W-1:0]     rd3_out,
  output logic [REG_ADDR_W-1:0] rr3_out,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned PW = 4 + 2 * DATA_W + REG_ADDR_W;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic [PW-1:0]   in_pld;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            main_valid;
  logic            stall;

  // Payload layout: {mem_to_reg, mem_read, mem_write, reg_write, alu, rd3, rr3}
  assign in_pld = {mem_to_reg_in, mem_read_in, mem_write_in, reg_write_in, alu_in, rd3_in, rr3_in};

  assign main_valid = (state_q != StEmpty);
  assign stall      = main_valid & ~out_ready & ~flush;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_valid) begin
            main_d  = in_pld;
            state_d = StOne;
          end
        end
        StOne: begin
          if (out_ready) begin
            // Consume and refill in the same edge keeps full throughput.
            if (in_valid) main_d = in_pld;
            else          state_d = StEmpty;
          end else if (in_valid) begin
            skid_d  = in_pld;
            state_d = StFull;
          end
        end
        StFull: begin
          if (out_ready) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready       = (state_q != StFull);
  assign out_valid      = main_valid;
  // Bubbles must never write memory or the register file.
  assign mem_to_reg_out = main_q[PW-1] & main_valid;
  assign mem_read_out   = main_q[PW-2] & main_valid;
  assign mem_write_out  = main_q[PW-3] & main_valid;
  assign reg_write_out  = main_q[PW-4] & main_valid;
  assign alu_out        = main_q[PW-5 -: DATA_W];
  assign rd3_out        = main_q[REG_ADDR_W +: DATA_W];
  assign rr3_out        = main_q[REG_ADDR_W-1:0];
  assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_segment_ex_mem_elastic.sv
// Bench for segment_ex_mem_elastic: directed scenarios then random traffic, every cycle checked
// against a 2-deep FIFO reference model with a saturating stall count.
module tb_segment_ex_mem_elastic;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;

  typedef struct packed {
    logic                  m2r;
    logic                  mr;
    logic                  mw;
    logic                  rw;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rd3;
    logic [REG_ADDR_W-1:0] rr3;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic mem_to_reg_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0, reg_write_in = 1'b0;
  logic [DATA_W-1:0] alu_in = '0, rd3_in = '0;
  logic [REG_ADDR_W-1:0] rr3_in = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic mem_to_reg_out, mem_read_out, mem_write_out, reg_write_out;
  logic [DATA_W-1:0] alu_out, rd3_out;
  logic [REG_ADDR_W-1:0] rr3_out;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad = 0;

  // Reference model: a FIFO of capacity 2, the last shown entry, and the stall count.
  ent_t q[$];
  ent_t shown;
  int   cnt;

  segment_ex_mem_elastic #(
    .DATA_W(DATA_W),
    .REG_ADDR_W(REG_ADDR_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_to_reg_in(mem_to_reg_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
    .alu_in(alu_in), .rd3_in(rd3_in), .rr3_in(rr3_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_to_reg_out(mem_to_reg_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .reg_write_out(reg_write_out),
    .alu_out(alu_out), .rd3_out(rd3_out), .rr3_out(rr3_out),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    shown = '0;
    cnt   = 0;
  endtask

  task automatic check_all(input string tag);
    logic v;
    v = (q.size() > 0);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
    chk({tag, ".ctrl"}, 64'({mem_to_reg_out, mem_read_out, mem_write_out, reg_write_out}),
        64'(v ? {shown.m2r, shown.mr, shown.mw, shown.rw} : 4'b0));
    chk({tag, ".alu"}, 64'(alu_out), 64'(shown.alu));
    chk({tag, ".rd3"}, 64'(rd3_out), 64'(shown.rd3));
    chk({tag, ".rr3"}, 64'(rr3_out), 64'(shown.rr3));
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(cnt));
  endtask

  function automatic ent_t mk(input logic [3:0] ctrl, input logic [DATA_W-1:0] alu);
    ent_t e;
    {e.m2r, e.mr, e.mw, e.rw} = ctrl;
    e.alu = alu;
    e.rd3 = alu ^ 32'h5A5A_0000;
    e.rr3 = alu[REG_ADDR_W-1:0] + 4'd1;
    return e;
  endfunction

  // Drive one cycle of inputs, advance through the falling edge, update model, check outputs.
  task automatic step(input string tag, input logic iv, input logic ordy, input logic fl,
                      input ent_t e);
    logic acc;
    in_valid = iv; out_ready = ordy; flush = fl;
    {mem_to_reg_in, mem_read_in, mem_write_in, reg_write_in} = {e.m2r, e.mr, e.mw, e.rw};
    alu_in = e.alu; rd3_in = e.rd3; rr3_in = e.rr3;
    @(negedge clk);
    if (fl) begin
      q.delete();
      shown = '0;
    end else begin
      if (q.size() > 0 && !ordy && cnt < int'(CNT_MAX)) cnt++;
      acc = iv && (q.size() < 2);
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (q.size() > 0) shown = q[0];
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("reset");
    #1 rst = 1'b0;
  endtask

  ent_t nil, ea, eb, ec, ed, er;

  initial begin
    nil = '0;
    model_reset();
    do_reset();

    // Stream 1,2,3 with no back-pressure.
    step("stream1", 1'b1, 1'b1, 1'b0, mk(4'b0000, 32'd1));
    chk("stream1_alu", 64'(alu_out), 64'd1);
    step("stream2", 1'b1, 1'b1, 1'b0, mk(4'b0000, 32'd2));
    chk("stream2_alu", 64'(alu_out), 64'd2);
    step("stream3", 1'b1, 1'b1, 1'b0, mk(4'b0000, 32'd3));
    chk("stream3_alu", 64'(alu_out), 64'd3);
    chk("stream_cnt", 64'(stall_cnt), 64'd0);
    step("stream_drain", 1'b0, 1'b1, 1'b0, nil);

    // Back-pressure: A in main, B into skid, C held off by EX.
    ea = mk(4'b0100, 32'hA); eb = mk(4'b0010, 32'hB); ec = mk(4'b1001, 32'hC);
    step("bp_a", 1'b1, 1'b0, 1'b0, ea);
    step("bp_b", 1'b1, 1'b0, 1'b0, eb);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    step("bp_c1", 1'b1, 1'b0, 1'b0, ec);
    step("bp_c2", 1'b1, 1'b0, 1'b0, ec);
    chk("bp_cnt", 64'(stall_cnt), 64'd3);
    chk("bp_hold_a", 64'(alu_out), 64'hA);
    step("bp_rel1", 1'b1, 1'b1, 1'b0, ec);
    chk("bp_out_b", 64'(alu_out), 64'hB);
    step("bp_rel2", 1'b1, 1'b1, 1'b0, ec);
    chk("bp_out_c", 64'(alu_out), 64'hC);
    step("bp_drain", 1'b0, 1'b1, 1'b0, nil);
    chk("bp_cnt_final", 64'(stall_cnt), 64'd3);

    // Bubble gating after drain.
    step("bub_load", 1'b1, 1'b1, 1'b0, mk(4'b0011, 32'hA));
    chk("bub_mw_on", 64'(mem_write_out), 64'd1);
    step("bub_drain", 1'b0, 1'b1, 1'b0, nil);
    chk("bub_mw_off", 64'(mem_write_out), 64'd0);
    chk("bub_rw_off", 64'(reg_write_out), 64'd0);
    chk("bub_alu_hold", 64'(alu_out), 64'hA);

    // Flush while FULL, with D presented in the same cycle.
    ed = mk(4'b1111, 32'hD);
    step("fl_a", 1'b1, 1'b0, 1'b0, ea);
    step("fl_b", 1'b1, 1'b0, 1'b0, eb);
    step("fl_flush", 1'b1, 1'b1, 1'b1, ed);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_alu_zero", 64'(alu_out), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    step("fl_after", 1'b0, 1'b1, 1'b0, nil);
    chk("fl_no_d", 64'(out_valid), 64'd0);

    // Asynchronous reset pulsed between edges while FULL.
    step("ar_a", 1'b1, 1'b0, 1'b0, ea);
    step("ar_b", 1'b1, 1'b0, 1'b0, eb);
    do_reset();
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_cnt", 64'(stall_cnt), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_data", 64'({alu_out, rr3_out}), 64'd0);

    // Saturation: 20 stalled edges on a 4-bit counter.
    step("sat_load", 1'b1, 1'b0, 1'b0, ea);
    for (int i = 0; i < 20; i++) step("sat", 1'b0, 1'b0, 1'b0, nil);
    chk("sat_cnt", 64'(stall_cnt), 64'd15);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      er.m2r = 1'($urandom); er.mr = 1'($urandom); er.mw = 1'($urandom); er.rw = 1'($urandom);
      er.alu = $urandom; er.rd3 = $urandom; er.rr3 = REG_ADDR_W'($urandom);
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) > 1),
           1'($urandom_range(0, 15) == 0), er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
